// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-back source/destination
// muxing, syscall read-index override and a per-register busy scoreboard.
// Optional write-to-read bypass is compiled in with `define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 2**ADDR_W-1,
  parameter int SYS_RA   = 2,
  parameter int SYS_RB   = 4
) (
  input  logic              in_clk,
  input  logic              in_RST,
  input  logic              in_we,
  input  logic [1:0]        in_wsel,
  input  logic [1:0]        in_wdst,
  input  logic [ADDR_W-1:0] in_p2,
  input  logic [ADDR_W-1:0] in_p4,
  input  logic [DATA_W-1:0] in_Memdata,
  input  logic [DATA_W-1:0] in_R,
  input  logic [DATA_W-1:0] in_pcout,
  input  logic [DATA_W-1:0] in_CPdata,
  input  logic              in_syscall,
  input  logic [ADDR_W-1:0] in_ra,
  input  logic [ADDR_W-1:0] in_rb,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  input  logic              in_iss_vld,
  input  logic [ADDR_W-1:0] in_iss_rd,
  output logic              out_stall,
  output logic [ADDR_W:0]   out_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] SYS_A    = ADDR_W'(SYS_RA);
  localparam logic [ADDR_W-1:0] SYS_B    = ADDR_W'(SYS_RB);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_cnt;

  logic [ADDR_W-1:0] rw;
  logic [DATA_W-1:0] w;
  logic              wr_en;
  logic [ADDR_W-1:0] ra_idx;
  logic [ADDR_W-1:0] rb_idx;
  logic              hit_a;
  logic              hit_b;
  logic              issue_ok;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  // Write-back destination and data selection; r0 writes are dropped.
  always_comb begin
    rw = LINK_IDX;
    case (in_wdst)
      2'd0:    rw = in_p2;
      2'd1:    rw = in_p4;
      default: rw = LINK_IDX;
    endcase
    w = in_Memdata;
    case (in_wsel)
      2'd0:    w = in_Memdata;
      2'd1:    w = in_R;
      2'd2:    w = in_pcout + DATA_W'(1);
      default: w = in_CPdata;
    endcase
    wr_en = in_we && (rw != '0);
  end

  // Read index override, optional bypass hit, combinational read ports.
  always_comb begin
    ra_idx = in_syscall ? SYS_A : in_ra;
    rb_idx = in_syscall ? SYS_B : in_rb;
`ifdef REGFILE_BYPASS_EN
    hit_a = wr_en && (rw == ra_idx);
    hit_b = wr_en && (rw == rb_idx);
`else
    hit_a = 1'b0;
    hit_b = 1'b0;
`endif
    if (ra_idx == '0)  out_A = '0;
    else if (hit_a)    out_A = w;
    else               out_A = regs[ra_idx];
    if (rb_idx == '0)  out_B = '0;
    else if (hit_b)    out_B = w;
    else               out_B = regs[rb_idx];
  end

  // Stall on busy operands; next busy vector where a new issue beats a clear.
  always_comb begin
    out_stall = (busy[ra_idx] && !hit_a) || (busy[rb_idx] && !hit_b);
    issue_ok  = in_iss_vld && !out_stall && (in_iss_rd != '0);
    busy_nxt  = busy;
    if (in_we)    busy_nxt[rw]        = 1'b0;
    if (issue_ok) busy_nxt[in_iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Register array, scoreboard and registered busy count.
  always_ff @(posedge in_clk) begin
    if (!in_RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_en) regs[rw] <= w;
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  assign out_busy_cnt = busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [1:0]  wsel, wdst;
  logic [4:0]  p2, p4;
  logic [31:0] memdata, rdat, pcout, cpdata;
  logic        syscall;
  logic [4:0]  ra, rb;
  logic [31:0] a, b;
  logic        iss_vld;
  logic [4:0]  iss_rd;
  logic        stall;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  bit          mbusy [32];

  regfile_sb dut (
    .in_clk(clk), .in_RST(rst_n), .in_we(we), .in_wsel(wsel), .in_wdst(wdst),
    .in_p2(p2), .in_p4(p4), .in_Memdata(memdata), .in_R(rdat), .in_pcout(pcout),
    .in_CPdata(cpdata), .in_syscall(syscall), .in_ra(ra), .in_rb(rb),
    .out_A(a), .out_B(b), .in_iss_vld(iss_vld), .in_iss_rd(iss_rd),
    .out_stall(stall), .out_busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [4:0] m_rw();
    if (wdst == 2'd0) return p2;
    if (wdst == 2'd1) return p4;
    return 5'd31;
  endfunction

  function automatic logic [31:0] m_w();
    case (wsel)
      2'd0: return memdata;
      2'd1: return rdat;
      2'd2: return pcout + 32'd1;
      default: return cpdata;
    endcase
  endfunction

  function automatic bit m_hit(input logic [4:0] idx);
    return BYP && we && idx != 0 && m_rw() == idx;
  endfunction

  function automatic logic [4:0] m_ra();
    return syscall ? 5'd2 : ra;
  endfunction

  function automatic logic [4:0] m_rb();
    return syscall ? 5'd4 : rb;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (m_hit(idx)) return m_w();
    return mregs[idx];
  endfunction

  function automatic logic m_stall();
    return (mbusy[m_ra()] && !m_hit(m_ra())) || (mbusy[m_rb()] && !m_hit(m_rb()));
  endfunction

  function automatic logic [5:0] m_cnt();
    int n = 0;
    foreach (mbusy[i]) n += int'(mbusy[i]);
    return 6'(n);
  endfunction

  // Advance one clock edge, updating the model with the inputs seen at it.
  task automatic tick();
    logic        acc;
    logic [4:0]  wi;
    logic [31:0] wd;
    acc = iss_vld && !m_stall() && iss_rd != 0;
    wi  = m_rw();
    wd  = m_w();
    @(posedge clk);
    if (!rst_n) begin
      foreach (mregs[i]) begin mregs[i] = 32'd0; mbusy[i] = 1'b0; end
    end else begin
      if (we && wi != 0) mregs[wi] = wd;
      if (we) mbusy[wi] = 1'b0;
      if (acc) mbusy[iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; we = 1'b0; wsel = 2'd0; wdst = 2'd0; p2 = 5'd0; p4 = 5'd0;
    memdata = 32'd0; rdat = 32'd0; pcout = 32'd0; cpdata = 32'd0;
    syscall = 1'b0; ra = 5'd0; rb = 5'd0; iss_vld = 1'b0; iss_rd = 5'd0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      #1;
      checks++;
      if (a !== 32'd0 || b !== 32'd0 || stall !== 1'b0 || busy_cnt !== 6'd0) begin
        errors++;
        $display("FAIL reset_read[%0d]: A=%h B=%h stall=%b cnt=%0d, required 0/0/0/0", i, a, b, stall, busy_cnt);
      end
    end
    // write to r0 is discarded
    we = 1'b1; wsel = 2'd1; wdst = 2'd0; p2 = 5'd0; rdat = 32'hDEADBEEF;
    tick();
    idle();
    #1;
    checks++;
    if (a !== 32'd0) begin
      errors++; $display("FAIL r0_write: A=%h, required 0", a);
    end
  endtask

  task automatic test_link_pc();
    logic [31:0] pcs [2];
    logic [31:0] exp [2];
    pcs[0] = 32'h00000FFF; exp[0] = 32'h00001000;
    pcs[1] = 32'hFFFFFFFF; exp[1] = 32'h00000000;
    for (int k = 0; k < 2; k++) begin
      idle();
      we = 1'b1; wdst = 2'd2; wsel = 2'd2; pcout = pcs[k];
      tick();
      idle();
      ra = 5'd31;
      #1;
      checks++;
      if (a !== exp[k] || a !== m_read(5'd31)) begin
        errors++; $display("FAIL link_pc[%0d]: r31=%h, required %h", k, a, exp[k]);
      end
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_vld = 1'b1; iss_rd = 5'd5;
    tick();
    idle();
    ra = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL sb_busy: stall=%b cnt=%0d, required 1/1", stall, busy_cnt);
    end
    we = 1'b1; wdst = 2'd0; p2 = 5'd5; wsel = 2'd0; memdata = 32'h1234;
    #1;
    checks++;
    if (BYP) begin
      if (stall !== 1'b0 || a !== 32'h1234) begin
        errors++; $display("FAIL sb_wb_cycle: stall=%b A=%h, required 0/00001234", stall, a);
      end
    end else begin
      if (stall !== 1'b1 || a !== m_read(5'd5)) begin
        errors++; $display("FAIL sb_wb_cycle: stall=%b A=%h, required 1/%h", stall, a, m_read(5'd5));
      end
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || a !== 32'h1234 || busy_cnt !== 6'd0) begin
      errors++; $display("FAIL sb_after_wb: stall=%b A=%h cnt=%0d, required 0/00001234/0", stall, a, busy_cnt);
    end
  endtask

  task automatic test_set_clear_same();
    idle();
    iss_vld = 1'b1; iss_rd = 5'd7;
    tick();
    // re-issue r7 together with its write-back
    iss_vld = 1'b1; iss_rd = 5'd7;
    we = 1'b1; wdst = 2'd1; p4 = 5'd7; wsel = 2'd3; cpdata = 32'hCAFE0007;
    tick();
    idle();
    rb = 5'd7;
    #1;
    checks++;
    if (busy_cnt !== 6'd1 || stall !== 1'b1 || b !== 32'hCAFE0007) begin
      errors++; $display("FAIL set_clear_same: cnt=%0d stall=%b B=%h, required 1/1/cafe0007", busy_cnt, stall, b);
    end
    we = 1'b1; wdst = 2'd0; p2 = 5'd7; wsel = 2'd1; rdat = 32'h77;
    rb = 5'd0;
    tick();
    idle();
  endtask

  task automatic test_syscall();
    logic [4:0]  idx [3];
    logic [31:0] val [3];
    idx[0] = 5'd2; val[0] = 32'h11;
    idx[1] = 5'd4; val[1] = 32'h22;
    idx[2] = 5'd9; val[2] = 32'h99;
    for (int k = 0; k < 3; k++) begin
      idle();
      we = 1'b1; wdst = 2'd0; p2 = idx[k]; wsel = 2'd1; rdat = val[k];
      tick();
    end
    idle();
    rdat = 32'hA0; we = 1'b1; p2 = 5'd10; wsel = 2'd1;
    tick();
    idle();
    syscall = 1'b1; ra = 5'd9; rb = 5'd10;
    #1;
    checks++;
    if (a !== 32'h11 || b !== 32'h22) begin
      errors++; $display("FAIL syscall: A=%h B=%h, required 00000011/00000022", a, b);
    end
    syscall = 1'b0;
    #1;
    checks++;
    if (a !== 32'h99 || b !== 32'hA0) begin
      errors++; $display("FAIL no_syscall: A=%h B=%h, required 00000099/000000a0", a, b);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    we = 1'b1; wdst = 2'd0; p2 = 5'd3; wsel = 2'd1; rdat = 32'h3333;
    tick();
    idle();
    iss_vld = 1'b1; iss_rd = 5'd3;
    tick();
    iss_rd = 5'd6;
    tick();
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd2) begin
      errors++; $display("FAIL mid_cnt: cnt=%0d, required 2", busy_cnt);
    end
    rst_n = 1'b0; we = 1'b1; p2 = 5'd3; wsel = 2'd1; rdat = 32'hBAD;
    iss_vld = 1'b1; iss_rd = 5'd8;
    tick();
    idle();
    ra = 5'd3; rb = 5'd6;
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || stall !== 1'b0 || a !== 32'd0) begin
      errors++; $display("FAIL reset_mid: cnt=%0d stall=%b r3=%h, required 0/0/0", busy_cnt, stall, a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_n   = ($urandom_range(0, 79) != 0);
      we      = $urandom_range(0, 1) == 1;
      wsel    = 2'($urandom_range(0, 3));
      wdst    = 2'($urandom_range(0, 3));
      p2      = 5'($urandom_range(0, 7));
      p4      = 5'($urandom_range(0, 31));
      memdata = $urandom(); rdat = $urandom(); cpdata = $urandom();
      pcout   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom();
      syscall = ($urandom_range(0, 7) == 0);
      ra      = 5'($urandom_range(0, 7));
      rb      = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      iss_vld = $urandom_range(0, 2) == 0;
      iss_rd  = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (a !== m_read(m_ra()) || b !== m_read(m_rb()) || stall !== m_stall() || busy_cnt !== m_cnt()) begin
        errors++;
        $display("FAIL random[%0d]: A=%h B=%h stall=%b cnt=%0d, required %h %h %b %0d",
                 n, a, b, stall, busy_cnt, m_read(m_ra()), m_read(m_rb()), m_stall(), m_cnt());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    foreach (mregs[i]) begin mregs[i] = 32'd0; mbusy[i] = 1'b0; end
    idle();
    test_reset();
    test_link_pc();
    test_scoreboard();
    test_set_clear_same();
    test_syscall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
